ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
// Shares the single-port 16-bit program/data RAM between two requesters: port 0 is the CPU
// fetch/execute path, port 1 is a loader/debug master that preloads or inspects RAM.
// Round-robin grant with optional burst lock and a bounded hold time.
// Sits between the requesters and the RAM. RAM writes on the falling clock edge and reads
// combinationally, so each granted cycle completes exactly one transfer.
// PARAMETERS
// AW        8   address width (RAM depth 2**AW)
// DW        16  data width
// MAX_HOLD  8   max consecutive granted cycles while the other port waits; 0 = no preemption
// PORTS
// clock     in   1   single system clock; all state updates on rising edge
// clear     in   1   reset, synchronous, active-high
// req0      in   1   port 0 transfer request, held until ack0
// we0       in   1   port 0 write enable (1 = write wdata0, 0 = read)
// lock0     in   1   port 0 burst lock; blocks hold-time preemption while high
// addr0     in   AW  port 0 address
// wdata0    in   DW  port 0 write data
// ack0      out  1   port 0 transfer done this cycle
// req1/we1/lock1/addr1/wdata1/ack1       same set for port 1
// gnt0      out  1   port 0 owns RAM (registered state decode)
// gnt1      out  1   port 1 owns RAM
// rdata     out  DW  RAM read data broadcast to both ports, valid when ackN=1 and weN=0
// ram_addr  out  AW  to RAM address
// ram_wdata out  DW  to RAM data in
// ram_we    out  1   to RAM write enable
// ram_rdata in   DW  from RAM data out
// BEHAVIOUR
// - States: IDLE, OWN0, OWN1 (registered). Also registered: last_owner (1 bit), hold_cnt.
// - Reset (clear=1 at a rising edge): state=IDLE, last_owner=1 (port 0 wins first tie),
//   hold_cnt=0. ram_we, ack0 and ack1 are forced 0 combinationally while clear=1.
// - IDLE:
//   - both req -> OWN(~last_owner); one req -> that port; none -> stay IDLE.
//   - Grant appears the cycle after req is sampled, so min request-to-ack latency is 1 cycle.
// - OWNx:
//   - ackx = reqx; combinational, same cycle.
//   - ram_addr/ram_wdata = addrx/wdatax; ram_we = reqx & wex.
//   - Each ack cycle is one complete transfer.
// - OWNx next state:
//   - reqx=0: OWN(other) if the other port requests (no idle bubble), else IDLE.
//   - reqx=1 & other req & lockx=0 & MAX_HOLD!=0 & hold_cnt==MAX_HOLD-1: OWN(other).
//     The current transfer still completes.
//   - otherwise stay in OWNx.
// - last_owner updates to x on every cycle in OWNx.
// - hold_cnt: +1 per ack cycle while the other port requests, saturating at MAX_HOLD-1.
//   Cleared to 0 on any grant change, and whenever the other port is not requesting.
// - IDLE outputs: ram_addr=0, ram_wdata=0, ram_we=0, ack0=ack1=0, gnt0=gnt1=0.
// - gnt0 and gnt1 are never both 1. ackN=1 implies gntN=1.
// - Dropping reqN mid-burst is legal: no transfer that cycle; release follows the rules above.
// - rdata = ram_rdata, unregistered.
// - Width rules: no arithmetic on address or data. hold_cnt width = clog2(MAX_HOLD), min 1.
// STRUCTURE
// - Shared include (ram_arb_defs.vh): state encodings IDLE=2'b00, OWN0=2'b01, OWN1=2'b10.
// - Sub-module arb_hold_counter: saturating counter with inc/clr/at_limit outputs.
//   Parameterised by MAX_HOLD.
// - Top contains the FSM plus the output mux, built from the existing MUX_2to1 cells per field.
// TESTING
// - clear=1 with req0=req1=1 -> ram_we=0, ack0=ack1=0; the cycle after clear drops, gnt0=1.
// - req0 only, we0=1, addr0=8'h10, wdata0=16'h00A5 -> gnt0 next cycle, ack0=1 that cycle.
//   Then a port-1 read of 8'h10 returns rdata=16'h00A5.
// - Both ports request continuously, lock=0, MAX_HOLD=8 -> grants alternate every 8 acks.
//   No idle cycle at the handover.
// - Same with lock1=1 -> port 1 keeps the grant until req1 drops, then port 0 is granted
//   next cycle.
// - Assert clear mid-burst in OWN1 -> IDLE next cycle; the next tie grants port 0.
// - MAX_HOLD=0, req0 held for 20 cycles with req1 pending -> port 0 keeps the grant;
//   gnt1 rises 1 cycle after req0 falls.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the two-port RAM arbiter.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwn0 = 2'b01,
    StOwn1 = 2'b10
  } arb_state_e;

  // Width of the hold counter; it never has to exceed MAX_HOLD-1.
  function automatic int unsigned hold_width(input int unsigned max_hold);
    return (max_hold <= 2) ? 1 : $clog2(max_hold);
  endfunction

endpackage

// File: rtl/ram_arbiter_hold_counter.sv
// Saturating count of consecutive granted cycles while the other port waits.
module ram_arbiter_hold_counter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam int unsigned CW       = hold_width(MAX_HOLD);
  localparam int unsigned LimitInt = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CW-1:0] Limit  = CW'(LimitInt);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != Limit)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // MAX_HOLD of zero disables preemption entirely.
  assign at_limit_o = (MAX_HOLD != 0) && (cnt_q == Limit);

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between CPU port 0 and loader port 1.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          req0,
  input  logic          we0,
  input  logic          lock0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic          lock1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       hold_inc, hold_clr, hold_at_limit;

  ram_arbiter_hold_counter #(
    .MAX_HOLD(MAX_HOLD)
  ) u_hold (
    .clk_i     (clock),
    .rst_i     (clear),
    .inc_i     (hold_inc),
    .clr_i     (hold_clr),
    .at_limit_o(hold_at_limit)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    ack0      = 1'b0;
    ack1      = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    hold_inc  = 1'b0;
    hold_clr  = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          state_d = last_q ? StOwn0 : StOwn1;
        end else if (req0) begin
          state_d = StOwn0;
        end else if (req1) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        last_d    = 1'b0;
        ack0      = req0;
        ram_addr  = addr0;
        ram_wdata = wdata0;
        ram_we    = req0 & we0;
        if (!req0) begin
          state_d = req1 ? StOwn1 : StIdle;
        end else if (req1 && !lock0 && hold_at_limit) begin
          state_d = StOwn1;
        end
        hold_inc = req0 & req1;
        hold_clr = !req1 || (state_d != state_q);
      end
      StOwn1: begin
        last_d    = 1'b1;
        ack1      = req1;
        ram_addr  = addr1;
        ram_wdata = wdata1;
        ram_we    = req1 & we1;
        if (!req1) begin
          state_d = req0 ? StOwn0 : StIdle;
        end else if (req0 && !lock1 && hold_at_limit) begin
          state_d = StOwn0;
        end
        hold_inc = req1 & req0;
        hold_clr = !req0 || (state_d != state_q);
      end
      default: state_d = StIdle;
    endcase
    // Nothing may reach the RAM while the arbiter is being cleared.
    if (clear) begin
      ack0   = 1'b0;
      ack1   = 1'b0;
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign gnt0  = (state_q == StOwn0);
  assign gnt1  = (state_q == StOwn1);
  assign rdata = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed table, corner sequences and random traffic vs a model.
module tb_ram_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        clear, req0, we0, lock0, req1, we1, lock1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;

  // Instance a: MAX_HOLD=8; instance b: MAX_HOLD=0.
  logic        ack0_a, ack1_a, gnt0_a, gnt1_a, we_a;
  logic [7:0]  addr_a;
  logic [15:0] wd_a, rd_a, rrd_a;
  logic        ack0_b, ack1_b, gnt0_b, gnt1_b, we_b;
  logic [7:0]  addr_b;
  logic [15:0] wd_b, rd_b, rrd_b;

  logic [15:0] ram_a [256];
  logic [15:0] ram_b [256];

  assign rrd_a = ram_a[addr_a];
  assign rrd_b = ram_b[addr_b];
  always @(negedge clock) if (we_a) ram_a[addr_a] <= wd_a;
  always @(negedge clock) if (we_b) ram_b[addr_b] <= wd_b;

  ram_arbiter #(.AW(8), .DW(16), .MAX_HOLD(8)) dut_a (
    .clock(clock), .clear(clear),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_a),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_a),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .rdata(rd_a), .ram_addr(addr_a), .ram_wdata(wd_a),
    .ram_we(we_a), .ram_rdata(rrd_a)
  );

  ram_arbiter #(.AW(8), .DW(16), .MAX_HOLD(0)) dut_b (
    .clock(clock), .clear(clear),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_b),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_b),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .rdata(rd_b), .ram_addr(addr_b), .ram_wdata(wd_b),
    .ram_we(we_b), .ram_rdata(rrd_b)
  );

  int vecs = 0;
  int miscompares = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: owner (-1 none), last owner, acks granted in a row while the other waits.
  int          m_owner [2];
  int          m_last  [2];
  int          m_run   [2];
  int          mh      [2] = '{8, 0};
  logic [15:0] m_mem   [2][256];
  bit          m_valid = 1'b0;

  task automatic get_out(input int k, output logic g0, g1, a0, a1, we,
                         output logic [7:0] ad, output logic [15:0] wd, rd);
    if (k == 0) begin
      g0 = gnt0_a; g1 = gnt1_a; a0 = ack0_a; a1 = ack1_a; we = we_a;
      ad = addr_a; wd = wd_a; rd = rd_a;
    end else begin
      g0 = gnt0_b; g1 = gnt1_b; a0 = ack0_b; a1 = ack1_b; we = we_b;
      ad = addr_b; wd = wd_b; rd = rd_b;
    end
  endtask

  task automatic model_check(input int k);
    int          o;
    logic        e_a0, e_a1, e_we, g0, g1, a0, a1, we;
    logic [7:0]  e_ad, ad;
    logic [15:0] e_wd, wd, rd;
    if (!m_valid) return;
    o    = m_owner[k];
    e_a0 = !clear && (o == 0) && req0;
    e_a1 = !clear && (o == 1) && req1;
    e_we = (e_a0 && we0) || (e_a1 && we1);
    e_ad = (o == 0) ? addr0 : (o == 1) ? addr1 : 8'h00;
    e_wd = (o == 0) ? wdata0 : (o == 1) ? wdata1 : 16'h0000;
    get_out(k, g0, g1, a0, a1, we, ad, wd, rd);
    cmp($sformatf("d%0d gnt0", k), g0, o == 0);
    cmp($sformatf("d%0d gnt1", k), g1, o == 1);
    cmp($sformatf("d%0d ack0", k), a0, e_a0);
    cmp($sformatf("d%0d ack1", k), a1, e_a1);
    cmp($sformatf("d%0d ram_we", k), we, e_we);
    cmp($sformatf("d%0d ram_addr", k), ad, e_ad);
    cmp($sformatf("d%0d ram_wdata", k), wd, e_wd);
    if ((e_a0 && !we0) || (e_a1 && !we1)) cmp($sformatf("d%0d rdata", k), rd, m_mem[k][e_ad]);
    if (e_we) m_mem[k][e_ad] = e_wd;
  endtask

  task automatic model_step(input int k);
    int x, o, nxt, limit;
    bit rx, ro, lx;
    if (clear) begin
      m_owner[k] = -1; m_last[k] = 1; m_run[k] = 0;
      return;
    end
    if (!m_valid) return;
    if (m_owner[k] < 0) begin
      if (req0 && req1) m_owner[k] = 1 - m_last[k];
      else if (req0)    m_owner[k] = 0;
      else if (req1)    m_owner[k] = 1;
      m_run[k] = 0;
      return;
    end
    x     = m_owner[k];
    o     = 1 - x;
    rx    = (x == 0) ? req0 : req1;
    ro    = (x == 0) ? req1 : req0;
    lx    = (x == 0) ? lock0 : lock1;
    limit = (mh[k] == 0) ? 0 : mh[k] - 1;
    m_last[k] = x;
    if (!rx)                                              nxt = ro ? o : -1;
    else if (ro && !lx && mh[k] != 0 && m_run[k] == limit) nxt = o;
    else                                                  nxt = x;
    if (nxt != x || !ro)     m_run[k] = 0;
    else if (m_run[k] < limit) m_run[k]++;
    m_owner[k] = nxt;
  endtask

  task automatic set_in(input bit c, r0, w0, l0, input logic [7:0] a0, input logic [15:0] d0,
                        input bit r1, w1, l1, input logic [7:0] a1, input logic [15:0] d1);
    clear = c; req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    #1;
  endtask

  task automatic end_cycle();
    model_check(0);
    model_check(1);
    model_step(0);
    model_step(1);
    if (clear) m_valid = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    set_in(1, 0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
    end_cycle();
  endtask

  typedef struct {
    bit          c, r0, w0;
    logic [7:0]  a0;
    logic [15:0] d0;
    bit          r1, w1;
    logic [7:0]  a1;
    bit          g0, g1, k0, k1, we, crd;
    logic [15:0] rd;
  } vec_t;

  function automatic vec_t mk(bit c, r0, w0, logic [7:0] a0, logic [15:0] d0, bit r1, w1,
                              logic [7:0] a1, bit g0, g1, k0, k1, we, crd, logic [15:0] rd);
    vec_t v;
    v.c = c; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.r1 = r1; v.w1 = w1; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.k0 = k0; v.k1 = k1; v.we = we; v.crd = crd; v.rd = rd;
    return v;
  endfunction

  vec_t tbl [10];

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_a[i] = 16'h0; ram_b[i] = 16'h0; m_mem[0][i] = 16'h0; m_mem[1][i] = 16'h0;
    end
    //            c  r0 w0 a0     d0        r1 w1 a1     g0 g1 k0 k1 we crd rd
    tbl[0] = mk(1, 1, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0);
    tbl[1] = mk(0, 1, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0);
    tbl[2] = mk(0, 1, 1, 8'h10, 16'h00A5, 0, 0, 8'h00, 1, 0, 1, 0, 1, 0, 16'h0);
    tbl[3] = mk(0, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h10, 1, 0, 0, 0, 0, 0, 16'h0);
    tbl[4] = mk(0, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h10, 0, 1, 0, 1, 0, 1, 16'h00A5);
    tbl[5] = mk(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 16'h0);
    tbl[6] = mk(0, 1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0);
    tbl[7] = mk(0, 1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 1, 0, 1, 0, 0, 1, 16'h00A5);
    tbl[8] = mk(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 16'h0);
    tbl[9] = mk(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0);

    do_clear();
    do_clear();
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].c, tbl[i].r0, tbl[i].w0, 0, tbl[i].a0, tbl[i].d0,
             tbl[i].r1, tbl[i].w1, 0, tbl[i].a1, 16'h0);
      cmp($sformatf("tbl%0d gnt0", i), gnt0_a, tbl[i].g0);
      cmp($sformatf("tbl%0d gnt1", i), gnt1_a, tbl[i].g1);
      cmp($sformatf("tbl%0d ack0", i), ack0_a, tbl[i].k0);
      cmp($sformatf("tbl%0d ack1", i), ack1_a, tbl[i].k1);
      cmp($sformatf("tbl%0d ram_we", i), we_a, tbl[i].we);
      if (tbl[i].crd) cmp($sformatf("tbl%0d rdata", i), rd_a, tbl[i].rd);
      end_cycle();
    end

    // Continuous contention: grants alternate every 8 acks, never idle at handover.
    do_clear();
    for (int i = 0; i < 34; i++) begin
      set_in(0, 1, 0, 0, 8'($urandom_range(0, 15)), 16'h0, 1, 0, 0, 8'($urandom_range(0, 15)),
             16'h0);
      if (i == 0) begin
        cmp("rr idle", {gnt0_a, gnt1_a}, 2'b00);
      end else begin
        cmp($sformatf("rr gnt0 c%0d", i), gnt0_a, ((i - 1) / 8) % 2 == 0);
        cmp($sformatf("rr gnt1 c%0d", i), gnt1_a, ((i - 1) / 8) % 2 == 1);
        cmp($sformatf("nohold gnt0 c%0d", i), gnt0_b, 1'b1);
      end
      end_cycle();
    end

    // Port 1 lock holds the grant past the hold limit until req1 drops.
    do_clear();
    for (int i = 0; i < 30; i++) begin
      set_in(0, 1, 0, 0, 8'h20, 16'h0, 1, 1, 1, 8'($urandom_range(0, 15)), 16'($urandom));
      if (i >= 1 && i <= 8) cmp($sformatf("lock gnt0 c%0d", i), gnt0_a, 1'b1);
      if (i >= 9) cmp($sformatf("lock gnt1 c%0d", i), gnt1_a, 1'b1);
      end_cycle();
    end
    set_in(0, 1, 0, 0, 8'h20, 16'h0, 0, 0, 1, 8'h00, 16'h0);
    cmp("lock release gnt1", gnt1_a, 1'b1);
    cmp("lock release ack1", ack1_a, 1'b0);
    end_cycle();
    set_in(0, 1, 0, 0, 8'h20, 16'h0, 0, 0, 0, 8'h00, 16'h0);
    cmp("lock handover gnt0", gnt0_a, 1'b1);
    cmp("lock handover ack0", ack0_a, 1'b1);
    end_cycle();

    // Clear mid-burst in OWN1, then a tie must go to port 0.
    do_clear();
    set_in(0, 0, 0, 0, 8'h00, 16'h0, 1, 1, 0, 8'h30, 16'h1234);
    end_cycle();
    set_in(0, 1, 0, 0, 8'h31, 16'h0, 1, 1, 0, 8'h30, 16'h5678);
    cmp("burst gnt1", gnt1_a, 1'b1);
    cmp("burst ack1", ack1_a, 1'b1);
    end_cycle();
    set_in(1, 1, 1, 0, 8'h31, 16'h0, 1, 1, 0, 8'h30, 16'h9ABC);
    cmp("midclr ack0", ack0_a, 1'b0);
    cmp("midclr ack1", ack1_a, 1'b0);
    cmp("midclr ram_we", we_a, 1'b0);
    end_cycle();
    set_in(0, 1, 0, 0, 8'h30, 16'h0, 1, 0, 0, 8'h30, 16'h0);
    cmp("postclr idle", {gnt0_a, gnt1_a}, 2'b00);
    end_cycle();
    set_in(0, 1, 0, 0, 8'h30, 16'h0, 1, 0, 0, 8'h30, 16'h0);
    cmp("postclr tie gnt0", gnt0_a, 1'b1);
    cmp("postclr rdata", rd_a, 16'h5678);
    end_cycle();

    // MAX_HOLD=0: port 0 keeps the grant for as long as it requests.
    do_clear();
    for (int i = 0; i < 21; i++) begin
      set_in(0, 1, 0, 0, 8'($urandom_range(0, 15)), 16'h0, 1, 0, 0, 8'h00, 16'h0);
      if (i >= 1) cmp($sformatf("nopre gnt0 c%0d", i), gnt0_b, 1'b1);
      end_cycle();
    end
    set_in(0, 0, 0, 0, 8'h00, 16'h0, 1, 0, 0, 8'h00, 16'h0);
    cmp("nopre drop gnt0", gnt0_b, 1'b1);
    cmp("nopre drop ack0", ack0_b, 1'b0);
    end_cycle();
    set_in(0, 0, 0, 0, 8'h00, 16'h0, 1, 0, 0, 8'h00, 16'h0);
    cmp("nopre gnt1", gnt1_b, 1'b1);
    cmp("nopre ack1", ack1_b, 1'b1);
    end_cycle();

    // Random traffic against the model on both instances.
    do_clear();
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0, 8'($urandom_range(0, 15)), 16'($urandom),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
             8'($urandom_range(0, 15)), 16'($urandom));
      end_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
